t09_lcd_cmd_sequencer: RTL and testbench

Sequencer that sits directly downstream of the game control FSM. It consumes that FSM's `init_cycle`, `en_update` and `sync_reset` levels and returns the `cmd_done` pulse that advances it. It drives an 8080-style 8-bit parallel LCD write bus: a fixed controller init sequence on `init_cycle`, and one filled square cell (window set plus pixel burst) on `en_update`.

---
 rtl/t09_lcd_cmd_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_t09_lcd_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/t09_lcd_cmd_sequencer.sv
// t09_lcd_cmd_sequencer
// Drives an 8080-style 8-bit LCD write bus on behalf of the game control FSM.
// On init_cycle it emits the controller init sequence (with two long settle
// delays); on en_update it writes one filled CELL_PX x CELL_PX square cell
// (column/row window set, memory write, pixel burst). Each bus byte takes two
// cycles: phase A with wr_n low, phase B with wr_n high and the byte held.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   init_cycle             level request: run the init sequence
//   en_update              level request: draw one cell (needs init_ok)
//   sync_reset             synchronous abort; also clears init_ok
//   cell_x, cell_y         cell column/row, latched at update start
//   cell_color             RGB565 fill colour, latched at update start
//   cmd_done               one-cycle pulse when a sequence completes
//   busy                   high from first bus cycle through the last one
//   init_ok                high once an init sequence has completed
//   lcd_cs_n, lcd_wr_n     chip select / write strobe (both active-low)
//   lcd_dcx, lcd_data      0 = command, 1 = data; bus byte
module t09_lcd_cmd_sequencer #(
  parameter int CELL_PX   = 10,
  parameter int DELAY_CYC = 1200000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        init_cycle,
  input  logic        en_update,
  input  logic        sync_reset,
  input  logic [4:0]  cell_x,
  input  logic [4:0]  cell_y,
  input  logic [15:0] cell_color,
  output logic        cmd_done,
  output logic        busy,
  output logic        init_ok,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_dcx,
  output logic [7:0]  lcd_data
);

  localparam int UPD_BYTES = 11 + 2 * CELL_PX * CELL_PX;
  localparam int IDX_W     = $clog2(UPD_BYTES);
  localparam int DLY_W     = (DELAY_CYC > 0) ? $clog2(DELAY_CYC + 1) : 1;

  localparam logic [IDX_W-1:0] UPD_LAST  = IDX_W'(UPD_BYTES - 1);
  localparam logic [IDX_W-1:0] INIT_LAST = IDX_W'(4);
  localparam logic [DLY_W-1:0] DLY_LOAD  = DLY_W'(DELAY_CYC);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_UPD, S_DONE} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;       // byte index within the sequence
  logic               ph, ph_nx;         // 0: next output is phase A, 1: phase B
  logic [DLY_W-1:0]   dly, dly_nx;       // remaining settle-delay cycles
  logic               is_init, is_init_nx;
  logic               latch_en;

  logic               cmd_done_nx, busy_nx, init_ok_nx;
  logic               cs_n_nx, wr_n_nx, dcx_nx;
  logic [7:0]         data_nx;

  logic [4:0]         cx, cy;
  logic [15:0]        col;
  logic [15:0]        xs, xe, ys, ye;
  logic [3:0]         idx_lo;
  logic               cur_dcx;
  logic [7:0]         cur_data;

  // Cell parameters are captured once so the caller may change them mid-burst.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      cx  <= cell_x;
      cy  <= cell_y;
      col <= cell_color;
    end
  end

  assign xs     = 16'(cx) * 16'(CELL_PX);
  assign xe     = xs + 16'(CELL_PX - 1);
  assign ys     = 16'(cy) * 16'(CELL_PX);
  assign ye     = ys + 16'(CELL_PX - 1);
  assign idx_lo = idx[3:0];

  // Byte selected by the current index. Pixel bytes start at index 11, so an
  // odd index is the colour high byte and an even one the low byte.
  always_comb begin
    cur_dcx  = 1'b0;
    cur_data = 8'h00;
    if (is_init) begin
      case (idx_lo)
        4'd0:    cur_data = 8'h01;
        4'd1:    cur_data = 8'h11;
        4'd2:    cur_data = 8'h3A;
        4'd3:    begin cur_dcx = 1'b1; cur_data = 8'h55; end
        default: cur_data = 8'h29;
      endcase
    end else if (idx >= IDX_W'(11)) begin
      cur_dcx  = 1'b1;
      cur_data = idx[0] ? col[15:8] : col[7:0];
    end else begin
      cur_dcx = 1'b1;
      case (idx_lo)
        4'd0:    begin cur_dcx = 1'b0; cur_data = 8'h2A; end
        4'd1:    cur_data = xs[15:8];
        4'd2:    cur_data = xs[7:0];
        4'd3:    cur_data = xe[15:8];
        4'd4:    cur_data = xe[7:0];
        4'd5:    begin cur_dcx = 1'b0; cur_data = 8'h2B; end
        4'd6:    cur_data = ys[15:8];
        4'd7:    cur_data = ys[7:0];
        4'd8:    cur_data = ye[15:8];
        4'd9:    cur_data = ye[7:0];
        default: begin cur_dcx = 1'b0; cur_data = 8'h2C; end
      endcase
    end
  end

  // Next-state and next-output logic; every output is registered from here,
  // so the bus lags the controlling state by one cycle.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    ph_nx       = ph;
    dly_nx      = dly;
    is_init_nx  = is_init;
    latch_en    = 1'b0;
    cmd_done_nx = 1'b0;
    busy_nx     = 1'b0;
    init_ok_nx  = init_ok;
    cs_n_nx     = 1'b1;
    wr_n_nx     = 1'b1;
    dcx_nx      = lcd_dcx;
    data_nx     = lcd_data;

    if (sync_reset) begin
      state_nx   = S_IDLE;
      init_ok_nx = 1'b0;
      idx_nx     = '0;
      ph_nx      = 1'b0;
      dly_nx     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          idx_nx = '0;
          ph_nx  = 1'b0;
          dly_nx = '0;
          if (init_cycle) begin
            state_nx   = S_INIT;
            is_init_nx = 1'b1;
          end else if (en_update && init_ok) begin
            state_nx   = S_UPD;
            is_init_nx = 1'b0;
            latch_en   = 1'b1;
          end
        end
        S_INIT, S_UPD: begin
          cs_n_nx = 1'b0;
          busy_nx = 1'b1;
          if (dly != '0) begin
            dly_nx = dly - 1'b1;
          end else if (!ph) begin
            wr_n_nx = 1'b0;
            dcx_nx  = cur_dcx;
            data_nx = cur_data;
            ph_nx   = 1'b1;
          end else begin
            ph_nx = 1'b0;
            if (idx == (is_init ? INIT_LAST : UPD_LAST)) begin
              state_nx = S_DONE;
            end else begin
              idx_nx = idx + 1'b1;
              // Software reset (0x01) and sleep-out (0x11) need settle time.
              if (is_init && idx <= IDX_W'(1)) dly_nx = DLY_LOAD;
            end
          end
        end
        S_DONE: begin
          cmd_done_nx = 1'b1;
          if (is_init) init_ok_nx = 1'b1;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      idx      <= '0;
      ph       <= 1'b0;
      dly      <= '0;
      is_init  <= 1'b0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
      init_ok  <= 1'b0;
      lcd_cs_n <= 1'b1;
      lcd_wr_n <= 1'b1;
      lcd_dcx  <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      ph       <= ph_nx;
      dly      <= dly_nx;
      is_init  <= is_init_nx;
      cmd_done <= cmd_done_nx;
      busy     <= busy_nx;
      init_ok  <= init_ok_nx;
      lcd_cs_n <= cs_n_nx;
      lcd_wr_n <= wr_n_nx;
      lcd_dcx  <= dcx_nx;
      lcd_data <= data_nx;
    end
  end

endmodule

// File: tb/tb_t09_lcd_cmd_sequencer.sv
// Testbench for t09_lcd_cmd_sequencer (CELL_PX=2, DELAY_CYC=4).
// Expected bus streams and cycle positions are derived from the byte lists
// and timing rules of the sequencer, then compared against the observed bus.
module tb_t09_lcd_cmd_sequencer;

  localparam int CELL_PX   = 2;
  localparam int DELAY_CYC = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        init_cycle = 1'b0;
  logic        en_update = 1'b0;
  logic        sync_reset = 1'b0;
  logic [4:0]  cell_x = '0;
  logic [4:0]  cell_y = '0;
  logic [15:0] cell_color = '0;
  logic        cmd_done, busy, init_ok;
  logic        lcd_cs_n, lcd_wr_n, lcd_dcx;
  logic [7:0]  lcd_data;

  int checks = 0;
  int failures = 0;

  t09_lcd_cmd_sequencer #(.CELL_PX(CELL_PX), .DELAY_CYC(DELAY_CYC)) dut (
    .clk(clk), .nrst(nrst), .init_cycle(init_cycle), .en_update(en_update),
    .sync_reset(sync_reset), .cell_x(cell_x), .cell_y(cell_y),
    .cell_color(cell_color), .cmd_done(cmd_done), .busy(busy),
    .init_ok(init_ok), .lcd_cs_n(lcd_cs_n), .lcd_wr_n(lcd_wr_n),
    .lcd_dcx(lcd_dcx), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, 32'(lcd_cs_n), 32'd1);
    chk({tag, "_wr_n"}, 32'(lcd_wr_n), 32'd1);
    chk({tag, "_dcx"}, 32'(lcd_dcx), 32'd0);
    chk({tag, "_data"}, 32'(lcd_data), 32'd0);
    chk({tag, "_cmd_done"}, 32'(cmd_done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_init_ok"}, 32'(init_ok), 32'd0);
  endtask

  // Watches an idle bus for ncyc cycles with en_update held at upd_req.
  task automatic idle_watch(input string tag, input int ncyc, input bit upd_req);
    int err = 0;
    en_update = upd_req;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (lcd_cs_n !== 1'b1 || lcd_wr_n !== 1'b1 || busy !== 1'b0 || cmd_done !== 1'b0) err++;
    end
    en_update = 1'b0;
    chk(tag, 32'(err), 32'd0);
  endtask

  // Starts a sequence at the next edge (E0) and checks it through cmd_done.
  // Returns at the negedge of the cmd_done cycle so calls can chain
  // back-to-back.
  task automatic run_seq(input string tag, input bit do_init, input bit also_upd,
                         input logic [4:0] x, input logic [4:0] y,
                         input logic [15:0] c, input bit hold);
    logic [8:0]  exp_b[$];
    int          exp_a[$];
    logic [8:0]  got_b[$];
    int          got_a[$];
    logic [15:0] xs, xe, ys, ye;
    logic [8:0]  last;
    int          t, exp_done, bus_err, hold_err, done_cnt, nmin;
    logic        done_end, init_ok_end;

    // Reference stream: {dcx, byte}
    if (do_init) begin
      exp_b = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h029};
    end else begin
      xs = 16'(x) * 16'(CELL_PX);
      xe = xs + 16'(CELL_PX - 1);
      ys = 16'(y) * 16'(CELL_PX);
      ye = ys + 16'(CELL_PX - 1);
      exp_b = '{9'h02A, {1'b1, xs[15:8]}, {1'b1, xs[7:0]}, {1'b1, xe[15:8]}, {1'b1, xe[7:0]},
                9'h02B, {1'b1, ys[15:8]}, {1'b1, ys[7:0]}, {1'b1, ye[15:8]}, {1'b1, ye[7:0]},
                9'h02C};
      for (int p = 0; p < CELL_PX * CELL_PX; p++) begin
        exp_b.push_back({1'b1, c[15:8]});
        exp_b.push_back({1'b1, c[7:0]});
      end
    end
    t = 1;
    for (int k = 0; k < exp_b.size(); k++) begin
      exp_a.push_back(t);
      t += 2;
      if (do_init && k < 2) t += DELAY_CYC;
    end
    exp_done = t;

    bus_err = 0; hold_err = 0; done_cnt = 0; last = 'x;
    done_end = 1'b0; init_ok_end = 1'b0;
    cell_x = x; cell_y = y; cell_color = c;
    init_cycle = do_init;
    en_update = also_upd | ~do_init;
    @(posedge clk);
    for (int n = 0; n <= exp_done; n++) begin
      @(negedge clk);
      if (busy !== (n >= 1 && n < exp_done) || lcd_cs_n !== !(n >= 1 && n < exp_done)) bus_err++;
      if (busy === 1'b1 && cmd_done === 1'b1) bus_err++;
      if (busy !== 1'b1 && lcd_wr_n !== 1'b1) bus_err++;
      if (cmd_done === 1'b1) done_cnt++;
      if (busy === 1'b1 && lcd_wr_n === 1'b0) begin
        last = {lcd_dcx, lcd_data};
        got_b.push_back(last);
        got_a.push_back(n);
      end else if (busy === 1'b1 && {lcd_dcx, lcd_data} !== last) begin
        hold_err++;
      end
      if (n == exp_done) begin
        done_end = cmd_done;
        init_ok_end = init_ok;
      end
      // The sequencer must use its latched copy, not the live inputs.
      cell_x = 5'($urandom_range(0, 31));
      cell_y = 5'($urandom_range(0, 31));
      cell_color = 16'($urandom);
      if (!hold && n == 0) begin
        init_cycle = 1'b0;
        en_update = 1'b0;
      end
    end
    init_cycle = 1'b0;
    en_update = 1'b0;

    chk({tag, "_nbytes"}, 32'(got_b.size()), 32'(exp_b.size()));
    nmin = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int k = 0; k < nmin; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), 32'(got_b[k]), 32'(exp_b[k]));
      chk($sformatf("%s_cyc%0d", tag, k), 32'(got_a[k]), 32'(exp_a[k]));
    end
    chk({tag, "_cs_busy_window"}, 32'(bus_err), 32'd0);
    chk({tag, "_phaseB_hold"}, 32'(hold_err), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_end), 32'd1);
    chk({tag, "_init_ok"}, 32'(init_ok_end), 32'd1);
  endtask

  initial begin
    int err;

    // Reset values
    #2 nrst = 1'b0;
    #10;
    chk_reset_outputs("reset");
    @(negedge clk);
    nrst = 1'b1;

    // Update requests before any init are ignored
    idle_watch("upd_before_init", 100, 1'b1);
    chk("upd_before_init_ok", 32'(init_ok), 32'd0);

    // Directed init, then directed update back-to-back
    run_seq("init", 1'b1, 1'b0, 5'd0, 5'd0, 16'h0000, 1'b1);
    run_seq("upd_dir", 1'b0, 1'b0, 5'd3, 5'd5, 16'hF81F, 1'b1);

    // Randomised updates, some chained, some separated by idle cycles
    for (int i = 0; i < 6; i++) begin
      run_seq($sformatf("upd_rnd%0d", i), 1'b0, 1'b0, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 23)), 16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    // Boundary cell (bottom-right corner)
    run_seq("upd_corner", 1'b0, 1'b0, 5'd31, 5'd23, 16'hFFFF, 1'b0);

    // Init wins over a simultaneous update request
    run_seq("init_prio", 1'b1, 1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 23)),
            16'($urandom), 1'b0);
    run_seq("upd_after_reinit", 1'b0, 1'b0, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 23)), 16'($urandom), 1'b0);

    // sync_reset in mid-update (high during cycle 15)
    @(negedge clk);
    cell_x = 5'd7; cell_y = 5'd9; cell_color = 16'h1234;
    en_update = 1'b1;
    @(posedge clk);
    err = 0;
    for (int n = 0; n <= 15; n++) begin
      @(negedge clk);
      if (cmd_done !== 1'b0) err++;
    end
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    en_update = 1'b0;
    chk("sreset_no_done_before", 32'(err), 32'd0);
    chk("sreset_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("sreset_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("sreset_busy", 32'(busy), 32'd0);
    chk("sreset_cmd_done", 32'(cmd_done), 32'd0);
    chk("sreset_init_ok", 32'(init_ok), 32'd0);
    idle_watch("sreset_upd_ignored", 60, 1'b1);

    // sync_reset overrides an init request in IDLE
    sync_reset = 1'b1;
    init_cycle = 1'b1;
    idle_watch("sreset_over_init", 6, 1'b0);
    sync_reset = 1'b0;
    init_cycle = 1'b0;

    // Asynchronous reset mid-init, then a full init and an update
    @(negedge clk);
    init_cycle = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    init_cycle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    run_seq("init_after_rst", 1'b1, 1'b0, 5'd0, 5'd0, 16'h0000, 1'b0);
    run_seq("upd_after_rst", 1'b0, 1'b0, 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 23)), 16'($urandom), 1'b1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
